// File: rtl/radiant_trig_coincidence.sv
// radiant_trig_coincidence: N-channel, M-trigger coincidence engine with
// per-trigger stretch, prescale, holdoff and a valid/ack event slot.
module radiant_trig_coincidence #(
  parameter int NUM_CH         = 24,
  parameter int NUM_TRIG       = 2,
  parameter int WINDOW_WIDTH   = 20,
  parameter int THRESH_WIDTH   = 5,
  parameter int HOLDOFF_WIDTH  = 16,
  parameter int PRESCALE_WIDTH = 8,
  parameter int DROP_WIDTH     = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_CH-1:0]                  trig_i,
  input  logic [NUM_TRIG*NUM_CH-1:0]         maskb_i,
  input  logic [NUM_TRIG-1:0]                en_i,
  input  logic [NUM_TRIG*WINDOW_WIDTH-1:0]   window_i,
  input  logic [NUM_TRIG*THRESH_WIDTH-1:0]   thresh_i,
  input  logic [NUM_TRIG*HOLDOFF_WIDTH-1:0]  holdoff_i,
  input  logic [NUM_TRIG*PRESCALE_WIDTH-1:0] prescale_i,
  input  logic                               evt_ack_i,
  input  logic                               drop_clear_i,
  output logic [NUM_TRIG-1:0]                trig_o,
  output logic [NUM_TRIG-1:0]                fire_o,
  output logic                               evt_valid_o,
  output logic [NUM_TRIG-1:0]                evt_type_o,
  output logic [DROP_WIDTH-1:0]              drop_count_o
);

  localparam int CNT_W = $clog2(NUM_CH + 1);
  localparam int CMP_W = (CNT_W > THRESH_WIDTH) ? CNT_W : THRESH_WIDTH;

  logic [NUM_CH-1:0]   trig_q;
  logic [NUM_CH-1:0]   ch_edge;
  logic [NUM_TRIG-1:0] fire;

  always_ff @(posedge clk_i) begin
    if (rst_i) trig_q <= '0;
    else       trig_q <= trig_i;
  end

  assign ch_edge = trig_i & ~trig_q;

  for (genvar t = 0; t < NUM_TRIG; t++) begin : g_trig
    logic [NUM_CH-1:0]         mask;
    logic [WINDOW_WIDTH-1:0]   win;
    logic [THRESH_WIDTH-1:0]   thr;
    logic [HOLDOFF_WIDTH-1:0]  hold;
    logic [PRESCALE_WIDTH-1:0] pre;
    logic [WINDOW_WIDTH-1:0]   str_cnt [NUM_CH];
    logic [NUM_CH-1:0]         active;
    logic [CNT_W-1:0]          n_act;
    logic                      above;
    logic                      trig_r;
    logic                      trig_p;
    logic                      cand;
    logic                      fire_r;
    logic [PRESCALE_WIDTH-1:0] pre_cnt;
    logic [HOLDOFF_WIDTH-1:0]  hold_cnt;

    assign mask = maskb_i[t*NUM_CH +: NUM_CH];
    assign win  = window_i[t*WINDOW_WIDTH +: WINDOW_WIDTH];
    assign thr  = thresh_i[t*THRESH_WIDTH +: THRESH_WIDTH];
    assign hold = holdoff_i[t*HOLDOFF_WIDTH +: HOLDOFF_WIDTH];
    assign pre  = prescale_i[t*PRESCALE_WIDTH +: PRESCALE_WIDTH];

    // A fresh edge reloads the window even mid-stretch (retrigger).
    always_ff @(posedge clk_i) begin
      if (rst_i || !en_i[t]) begin
        for (int c = 0; c < NUM_CH; c++) str_cnt[c] <= '0;
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_edge[c])
            str_cnt[c] <= win;
          else if (str_cnt[c] != '0)
            str_cnt[c] <= str_cnt[c] - WINDOW_WIDTH'(1);
        end
      end
    end

    always_comb begin
      active = '0;
      n_act  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        active[c] = (str_cnt[c] != '0);
        n_act     = n_act + CNT_W'(active[c] & mask[c]);
      end
    end

    assign above = (thr != '0) && (CMP_W'(n_act) >= CMP_W'(thr));
    assign cand  = trig_r & ~trig_p;

    always_ff @(posedge clk_i) begin
      if (rst_i || !en_i[t]) begin
        trig_r   <= 1'b0;
        trig_p   <= 1'b0;
        fire_r   <= 1'b0;
        pre_cnt  <= '0;
        hold_cnt <= '0;
      end else begin
        trig_r <= above;
        trig_p <= trig_r;
        fire_r <= 1'b0;
        if (hold_cnt != '0)
          hold_cnt <= hold_cnt - HOLDOFF_WIDTH'(1);
        // Candidates inside holdoff are ignored and do not advance prescale.
        if (cand && hold_cnt == '0) begin
          if (pre_cnt == pre) begin
            pre_cnt  <= '0;
            hold_cnt <= hold;
            fire_r   <= 1'b1;
          end else begin
            pre_cnt <= pre_cnt + PRESCALE_WIDTH'(1);
          end
        end
      end
    end

    assign trig_o[t] = trig_r;
    assign fire[t]   = fire_r;
  end

  assign fire_o = fire;

  logic fire_any;
  logic slot_free;
  logic drop_now;

  assign fire_any  = |fire;
  assign slot_free = ~evt_valid_o | evt_ack_i;
  assign drop_now  = fire_any & ~slot_free;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      evt_valid_o  <= 1'b0;
      evt_type_o   <= '0;
      drop_count_o <= '0;
    end else begin
      unique case (1'b1)
        fire_any && slot_free: begin
          evt_valid_o <= 1'b1;
          evt_type_o  <= fire;
        end
        !fire_any && evt_ack_i: evt_valid_o <= 1'b0;
        default: ;
      endcase
      if (drop_clear_i)
        drop_count_o <= DROP_WIDTH'(drop_now);
      else if (drop_now && !(&drop_count_o))
        drop_count_o <= drop_count_o + DROP_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_radiant_trig_coincidence.sv
// tb_radiant_trig_coincidence: scoreboard bench for the coincidence engine,
// 24 channels, 2 triggers, 4-bit drop counter.
module tb_radiant_trig_coincidence;

  localparam int NC = 24;
  localparam int NT = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [NC-1:0] trig_i;
  logic [NT*NC-1:0] maskb_i;
  logic [NT-1:0] en_i;
  logic [NT*20-1:0] window_i;
  logic [NT*5-1:0]  thresh_i;
  logic [NT*16-1:0] holdoff_i;
  logic [NT*8-1:0]  prescale_i;
  logic          evt_ack_i;
  logic          drop_clear_i;
  logic [NT-1:0] trig_o;
  logic [NT-1:0] fire_o;
  logic          evt_valid_o;
  logic [NT-1:0] evt_type_o;
  logic [3:0]    drop_count_o;

  radiant_trig_coincidence #(
    .NUM_CH(NC), .NUM_TRIG(NT), .DROP_WIDTH(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .trig_i(trig_i),
    .maskb_i(maskb_i), .en_i(en_i), .window_i(window_i),
    .thresh_i(thresh_i), .holdoff_i(holdoff_i),
    .prescale_i(prescale_i), .evt_ack_i(evt_ack_i),
    .drop_clear_i(drop_clear_i), .trig_o(trig_o),
    .fire_o(fire_o), .evt_valid_o(evt_valid_o),
    .evt_type_o(evt_type_o), .drop_count_o(drop_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         cyc;
    logic [1:0] val;
  } exp_t;

  exp_t fq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  bit   ack_hold = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at(input int c);
    while (cyc < c) step();
    @(negedge clk_i);
  endtask

  // Fire scoreboard: each observed pulse pops the oldest expectation.
  always @(negedge clk_i) begin
    if (fire_o != '0) begin
      if (fq.size() == 0) begin
        chk("fire_unexp", 32'(fire_o), 32'd0);
      end else begin
        exp_t e;
        e = fq.pop_front();
        chk("fire_cyc", cyc, e.cyc);
        chk("fire_val", 32'(fire_o), 32'(e.val));
      end
    end
  end

  task automatic shot(input logic [1:0] exp, input bit ack_f,
                      input bit clr_f);
    int   s;
    exp_t e;
    s = cyc;
    if (exp != 2'b00) begin
      e.cyc = s + 3;
      e.val = exp;
      fq.push_back(e);
    end
    trig_i[2:0] = 3'b111;
    step();
    trig_i[2:0] = 3'b000;
    while (cyc < s + 3) step();
    evt_ack_i    = ack_hold | ack_f;
    drop_clear_i = clr_f;
    step();
    evt_ack_i    = ack_hold;
    drop_clear_i = 1'b0;
    while (cyc < s + 20) step();
  endtask

  task automatic pulse_ch(input int c);
    trig_i[c] = 1'b1;
    step();
    trig_i[c] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: cyc %0d expected below 5000", cyc);
    $fatal(1);
  end

  initial begin
    int   s;
    bit   seen;
    exp_t e;
    rst_i        = 1'b1;
    trig_i       = '0;
    maskb_i      = '1;
    en_i         = 2'b01;
    window_i     = {20'd10, 20'd10};
    thresh_i     = {5'd3, 5'd3};
    holdoff_i    = '0;
    prescale_i   = '0;
    evt_ack_i    = 1'b0;
    drop_clear_i = 1'b0;
    repeat (3) step();
    rst_i = 1'b0;
    at(cyc);
    chk("rst_trig", 32'(trig_o), 32'd0);
    chk("rst_fire", 32'(fire_o), 32'd0);
    chk("rst_valid", 32'(evt_valid_o), 32'd0);
    chk("rst_type", 32'(evt_type_o), 32'd0);
    chk("rst_drop", 32'(drop_count_o), 32'd0);

    ack_hold  = 1'b1;
    evt_ack_i = 1'b1;
    step();
    s = cyc;
    e.cyc = s + 11;
    e.val = 2'b01;
    fq.push_back(e);
    pulse_ch(0);
    while (cyc < s + 4) step();
    pulse_ch(5);
    while (cyc < s + 8) step();
    pulse_ch(9);
    at(s + 9);
    chk("coinc_trig_early", 32'(trig_o[0]), 32'd0);
    at(s + 10);
    chk("coinc_trig", 32'(trig_o[0]), 32'd1);
    at(s + 12);
    chk("coinc_valid", 32'(evt_valid_o), 32'd1);
    chk("coinc_type", 32'(evt_type_o), 32'd1);
    while (cyc < s + 30) step();

    s = cyc;
    pulse_ch(0);
    while (cyc < s + 4) step();
    pulse_ch(5);
    while (cyc < s + 11) step();
    pulse_ch(9);
    seen = 1'b0;
    repeat (20) begin
      step();
      @(negedge clk_i);
      seen |= trig_o[0];
    end
    chk("late_no_trig", 32'(seen), 32'd0);

    prescale_i[7:0] = 8'd2;
    shot(2'b00, 0, 0);
    shot(2'b00, 0, 0);
    shot(2'b01, 0, 0);
    shot(2'b00, 0, 0);
    shot(2'b00, 0, 0);
    shot(2'b01, 0, 0);

    prescale_i[7:0] = 8'd0;
    holdoff_i[15:0] = 16'd50;
    shot(2'b01, 0, 0);
    shot(2'b00, 0, 0);
    shot(2'b00, 0, 0);
    shot(2'b01, 0, 0);
    shot(2'b00, 0, 0);
    shot(2'b00, 0, 0);
    holdoff_i[15:0] = 16'd0;
    repeat (30) step();

    ack_hold  = 1'b0;
    evt_ack_i = 1'b0;
    shot(2'b01, 0, 0);
    at(cyc);
    chk("hs_valid", 32'(evt_valid_o), 32'd1);
    repeat (3) shot(2'b01, 0, 0);
    at(cyc);
    chk("hs_drop3", 32'(drop_count_o), 32'd3);
    chk("hs_type_kept", 32'(evt_type_o), 32'd1);
    en_i = 2'b10;
    shot(2'b10, 1, 0);
    at(cyc);
    chk("ackfire_valid", 32'(evt_valid_o), 32'd1);
    chk("ackfire_type", 32'(evt_type_o), 32'd2);
    chk("ackfire_drop", 32'(drop_count_o), 32'd3);
    drop_clear_i = 1'b1;
    step();
    drop_clear_i = 1'b0;
    at(cyc);
    chk("drop_clear", 32'(drop_count_o), 32'd0);

    repeat (20) shot(2'b10, 0, 0);
    at(cyc);
    chk("drop_sat", 32'(drop_count_o), 32'd15);
    shot(2'b10, 0, 1);
    at(cyc);
    chk("clr_and_drop", 32'(drop_count_o), 32'd1);
    evt_ack_i = 1'b1;
    step();
    evt_ack_i = 1'b0;
    at(cyc);
    chk("ack_clears", 32'(evt_valid_o), 32'd0);
    drop_clear_i = 1'b1;
    step();
    drop_clear_i = 1'b0;

    en_i = 2'b11;
    step();
    s = cyc;
    e.cyc = s + 3;
    e.val = 2'b01;
    fq.push_back(e);
    trig_i[2:0] = 3'b111;
    step();
    trig_i[2:0] = 3'b000;
    en_i = 2'b01;
    at(s + 2);
    chk("dis_trig1", 32'(trig_o[1]), 32'd0);
    chk("dis_trig0", 32'(trig_o[0]), 32'd1);
    at(s + 4);
    chk("dis_type", 32'(evt_type_o), 32'd1);
    while (cyc < s + 20) step();
    evt_ack_i = 1'b1;
    step();
    evt_ack_i = 1'b0;
    en_i = 2'b11;
    repeat (5) step();

    shot(2'b11, 0, 0);
    at(cyc);
    chk("sim_valid", 32'(evt_valid_o), 32'd1);
    chk("sim_type", 32'(evt_type_o), 32'd3);
    chk("sim_drop", 32'(drop_count_o), 32'd0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    at(cyc);
    chk("mid_rst_valid", 32'(evt_valid_o), 32'd0);
    chk("mid_rst_type", 32'(evt_type_o), 32'd0);
    chk("mid_rst_drop", 32'(drop_count_o), 32'd0);
    chk("mid_rst_trig", 32'(trig_o), 32'd0);
    chk("mid_rst_fire", 32'(fire_o), 32'd0);
    repeat (5) step();
    chk("fq_empty", 32'(fq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
